// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC result link (controller, receiver, benches).
package sar_adc_pkg;

   // ADC result width carried by one serial frame
   localparam int ADC_DATA_W      = 8;
   // Default mid-frame silence (clk cycles) before a partial frame is abandoned
   localparam int DEF_TIMEOUT_CYC = 255;

   // Receiver FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_PUSH  = 2'd2;

endpackage

// File: rtl/sar_rx_fifo.sv
// Small synchronous word FIFO with first-word-fall-through head and
// simultaneous push+pop allowed while full.
module sar_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              do_push, do_pop;

   // Status flags, accepted operations and head-of-queue data
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop & ~empty;
      // a full FIFO still takes a word when the head leaves in the same cycle
      do_push  = push & (~full | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer registers; extra MSB distinguishes full from empty
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/sar_spi_result_receiver.sv
// Receiving end of the SAR ADC serial result link: synchronises sclk/miso/
// adc_done, deserialises frames into words and buffers them for a consumer.
module sar_spi_result_receiver
   import sar_adc_pkg::*;
#(
   parameter int DATA_W      = ADC_DATA_W,
   parameter int SYNC_STAGES = 2,
   parameter int MSB_FIRST   = 1,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_sclk,
   input  logic              spi_miso,
   input  logic              adc_done,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overflow,
   input  logic              clear_status
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
   logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
   logic sclk_prev_q, sclk_prev_d, done_prev_q, done_prev_d;
   logic rise_q, rise_d, bit_q, bit_d, done_rise_q, done_rise_d;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              frame_err_q, frame_err_d;
   logic              overflow_q, overflow_d;
   logic              push, pop, fifo_empty, fifo_full;

   // Insert one received bit according to the configured bit order
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                  input logic b);
      if (MSB_FIRST != 0) return {cur[DATA_W-2:0], b};
      else                return {b, cur[DATA_W-1:1]};
   endfunction

   // Synchroniser chains and registered edge detection (miso sampled with the edge)
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], spi_miso};
      done_sync_d = {done_sync_q[SYNC_STAGES-2:0], adc_done};
      sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
      done_prev_d = done_sync_q[SYNC_STAGES-1];
      rise_d      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      done_rise_d = done_sync_q[SYNC_STAGES-1] & ~done_prev_q;
      bit_d       = miso_sync_q[SYNC_STAGES-1];
   end

   // Frame FSM: collect DATA_W bits, push the word, abort on timeout or early adc_done
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idle_d      = idle_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            idle_d = '0;
            if (rise_q) begin
               shift_d = shift_in('0, bit_q);
               cnt_d   = CNT_W'(1);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_FULL) begin
               idle_d  = '0;
               state_d = ST_PUSH;
            end else if (done_rise_q && (cnt_q != '0)) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               idle_d      = '0;
               state_d     = ST_IDLE;
            end else if (rise_q) begin
               shift_d = shift_in(shift_q, bit_q);
               cnt_d   = cnt_q + CNT_W'(1);
               idle_d  = '0;
            end else if (idle_q >= IDLE_LAST) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               idle_d      = '0;
               state_d     = ST_IDLE;
            end else if (idle_q != IDLE_MAX) begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         ST_PUSH: begin
            push   = 1'b1;
            idle_d = '0;
            // an sclk rise landing here starts the next frame
            if (rise_q) begin
               shift_d = shift_in('0, bit_q);
               cnt_d   = CNT_W'(1);
               state_d = ST_SHIFT;
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            idle_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky overflow: a word was dropped; clear_status wins over a new drop
   always_comb begin
      pop        = ~fifo_empty & rx_ready;
      overflow_d = overflow_q | (push & fifo_full & ~pop);
      if (clear_status) overflow_d = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         miso_sync_q <= '0;
         done_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         done_prev_q <= 1'b0;
         rise_q      <= 1'b0;
         done_rise_q <= 1'b0;
         bit_q       <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idle_q      <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         miso_sync_q <= miso_sync_d;
         done_sync_q <= done_sync_d;
         sclk_prev_q <= sclk_prev_d;
         done_prev_q <= done_prev_d;
         rise_q      <= rise_d;
         done_rise_q <= done_rise_d;
         bit_q       <= bit_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idle_q      <= idle_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   sar_rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .rd_data   (rx_data),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign rx_valid  = ~fifo_empty;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_sar_spi_result_receiver.sv
// Directed bench for the SAR ADC result receiver with an expected-word scoreboard.
module tb_sar_spi_result_receiver;

   localparam int S  = 2;
   localparam int TO = 255;

   logic       clk = 1'b0;
   logic       reset, spi_sclk, spi_miso, adc_done, rx_ready, clear_status;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overflow;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   sar_spi_result_receiver #(
      .DATA_W      (8),
      .SYNC_STAGES (S),
      .MSB_FIRST   (1),
      .TIMEOUT_CYC (TO),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .spi_sclk     (spi_sclk),
      .spi_miso     (spi_miso),
      .adc_done     (adc_done),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .frame_err    (frame_err),
      .overflow     (overflow),
      .clear_status (clear_status)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // advance n clock edges, landing 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      spi_sclk = 1'b0;
      spi_miso = b;
      step(2);
      spi_sclk = 1'b1;
      step(2);
   endtask

   // send the first nbits of a frame (MSB first), sclk left high after the last
   task automatic send_bits(input logic [7:0] d, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(d[7-i]);
   endtask

   // full frame followed by sclk low
   task automatic send_frame(input logic [7:0] d);
      send_bits(d, 8);
      spi_sclk = 1'b0;
      step(2);
   endtask

   // pop one word once it appears and compare against the scoreboard head
   task automatic pop_one(input string tag);
      logic [7:0] exp;
      int         waited;
      waited = 0;
      while (!rx_valid && waited < 60) begin
         step(1);
         waited++;
      end
      check({tag, "_valid"}, 32'(rx_valid), 32'(1));
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      else exp = 8'h00;
      check({tag, "_data"}, 32'(rx_data), 32'(exp));
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
   endtask

   initial begin : stim
      int err_cnt;
      int err_at;

      reset = 1'b1; spi_sclk = 1'b0; spi_miso = 1'b0; adc_done = 1'b0;
      rx_ready = 1'b0; clear_status = 1'b0;

      // reset held 5 cycles with sclk/miso toggling
      for (int i = 0; i < 5; i++) begin
         spi_sclk = ~spi_sclk;
         spi_miso = ~spi_miso;
         step(1);
      end
      check("rst_valid", 32'(rx_valid), 32'(0));
      check("rst_data", 32'(rx_data), 32'(0));
      check("rst_ferr", 32'(frame_err), 32'(0));
      check("rst_ovf", 32'(overflow), 32'(0));
      spi_sclk = 1'b0;
      spi_miso = 1'b0;
      step(1);
      reset = 1'b0;
      step(8);
      check("post_rst_valid", 32'(rx_valid), 32'(0));

      // single frame 0x8C with exact latency measurement
      exp_q.push_back(8'h8C);
      send_bits(8'h8C, 7);
      spi_sclk = 1'b0;
      spi_miso = 1'b0;
      step(2);
      spi_sclk = 1'b1;
      step(S + 3);
      check("lat_early", 32'(rx_valid), 32'(0));
      step(1);
      check("lat_exact", 32'(rx_valid), 32'(1));
      spi_sclk = 1'b0;
      step(2);
      pop_one("f8c");
      check("f8c_drop", 32'(rx_valid), 32'(0));
      // adc_done outside a frame is ignored
      adc_done = 1'b1;
      step(3);
      adc_done = 1'b0;
      step(6);
      check("done_idle_ferr", 32'(frame_err), 32'(0));

      // five frames with consumer stalled: fifth is dropped
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back(8'(i));
         send_frame(8'(i));
      end
      step(10);
      check("ovf_set", 32'(overflow), 32'(1));
      for (int i = 0; i < 4; i++) pop_one("drain");
      check("drain_empty", 32'(rx_valid), 32'(0));
      check("ovf_sticky", 32'(overflow), 32'(1));
      clear_status = 1'b1;
      step(1);
      clear_status = 1'b0;
      check("ovf_clear", 32'(overflow), 32'(0));

      // three bits then silence: one frame_err pulse near the timeout
      send_bits(8'hE0, 3);
      spi_sclk = 1'b0;
      err_cnt = 0;
      err_at = -1;
      for (int c = 0; c < 300; c++) begin
         step(1);
         if (frame_err) begin
            err_cnt++;
            err_at = c;
         end
      end
      check("to_pulses", 32'(err_cnt), 32'(1));
      check("to_window", 32'((err_at >= TO - 5) && (err_at <= TO + 5)), 32'(1));
      exp_q.push_back(8'hA5);
      send_frame(8'hA5);
      pop_one("after_to");

      // three bits then adc_done: frame abandoned
      send_bits(8'h60, 3);
      spi_sclk = 1'b0;
      step(1);
      adc_done = 1'b1;
      err_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 3) adc_done = 1'b0;
         step(1);
         if (frame_err) err_cnt++;
      end
      check("done_pulses", 32'(err_cnt), 32'(1));
      check("done_no_word", 32'(rx_valid), 32'(0));
      exp_q.push_back(8'hC3);
      send_frame(8'hC3);
      pop_one("after_done");

      // FIFO full, consumer pops exactly as 0x3C is pushed
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h11 + 8'(i));
         send_frame(8'h11 + 8'(i));
      end
      exp_q.push_back(8'h3C);
      send_bits(8'h3C, 7);
      spi_sclk = 1'b0;
      spi_miso = 1'b0;
      step(2);
      spi_sclk = 1'b1;
      step(S + 3);
      check("full_head", 32'(rx_data), 32'(exp_q.pop_front()));
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      spi_sclk = 1'b0;
      step(4);
      check("pp_no_ovf", 32'(overflow), 32'(0));
      for (int i = 0; i < 4; i++) pop_one("pp_drain");
      check("pp_empty", 32'(rx_valid), 32'(0));

      // reset in the middle of a frame discards it
      send_bits(8'hFF, 4);
      spi_sclk = 1'b0;
      step(1);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(4);
      check("midrst_valid", 32'(rx_valid), 32'(0));
      exp_q.push_back(8'h5A);
      send_frame(8'h5A);
      pop_one("f5a");
      step(4);
      check("f5a_only", 32'(rx_valid), 32'(0));
      check("sb_empty", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
